// File: rtl/serial_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_feeder_pkg
//  Description : Shared types and helpers for the serial_feeder block.
//                - feeder_state_t : FSM state encoding (FS_IDLE, FS_SHIFT)
//                - cnt_width()    : bit counter width for a given word width
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_feeder_pkg;

   typedef enum logic {
      FS_IDLE  = 1'b0,
      FS_SHIFT = 1'b1
   } feeder_state_t;

   // Counter must index 0..w-1; w is always >= 2, so the result is >= 1.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage : serial_feeder_pkg
`default_nettype wire

// File: rtl/serial_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_feeder
//  Description : Parallel-to-serial front end feeding the 1011 sequence
//                detector. Words arrive over valid/ready, are shifted out one
//                bit per clock on sout; a one-word holding register allows
//                gapless streaming of consecutive words.
//  Ports       : clk, rst_n (async, active low)
//                load_valid / load_ready / load_data : parallel word input
//                sout, sout_valid, word_done         : serial output
//                busy                                : word shifting or held
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_feeder
   import serial_feeder_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             sout,
   output logic             sout_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int unsigned    CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   feeder_state_t    state_q,     state_d;
   logic [WIDTH-1:0] shift_q,     shift_d;
   logic [WIDTH-1:0] hold_q,      hold_d;
   logic             hold_full_q, hold_full_d;
   logic [CW-1:0]    cnt_q,       cnt_d;

   logic             accept_w;
   logic             last_bit_w;
   logic [WIDTH-1:0] shift_adv_w;

   assign load_ready = !hold_full_q;
   assign accept_w   = load_valid && load_ready;
   assign last_bit_w = (state_q == FS_SHIFT) && (cnt_q == CNT_LAST);

   // Next shift-register contents after emitting the current bit.
   always_comb begin
      if (MSB_FIRST) begin
         shift_adv_w = {shift_q[WIDTH-2:0], 1'b0};
      end else begin
         shift_adv_w = {1'b0, shift_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;

      case (state_q)
         FS_IDLE: begin
            if (accept_w) begin
               shift_d = load_data;
               cnt_d   = '0;
               state_d = FS_SHIFT;
            end
         end

         FS_SHIFT: begin
            if (!last_bit_w) begin
               shift_d = shift_adv_w;
               cnt_d   = cnt_q + CW'(1);
               if (accept_w) begin
                  hold_d      = load_data;
                  hold_full_d = 1'b1;
               end
            end else if (accept_w) begin
               // Holding register is empty here (accept implies it), so the
               // new word goes straight in behind the last bit.
               shift_d = load_data;
               cnt_d   = '0;
            end else if (hold_full_q) begin
               shift_d     = hold_q;
               hold_full_d = 1'b0;
               cnt_d       = '0;
            end else begin
               cnt_d   = '0;
               state_d = FS_IDLE;
            end
         end

         default: begin
            state_d = FS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FS_IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
      end
   end

   assign sout_valid = (state_q == FS_SHIFT);
   assign sout       = sout_valid ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0])
                                  : IDLE_BIT;
   assign word_done  = last_bit_w;
   assign busy       = sout_valid || hold_full_q;

endmodule : serial_feeder
`default_nettype wire

// File: tb/tb_serial_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_feeder
//  Description : Directed self-checking bench for serial_feeder. Cycle c is
//                the clock period in which inputs are presented; a word
//                presented in cycle 0 is shifted out in cycles 1..8.
//                Includes a reference 1011 Moore detector on the MSB-first
//                stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_feeder;

   logic       clk;
   logic       rst_n;

   logic       lv1, lr1, so1, sv1, wd1, bz1;
   logic [7:0] ld1;
   logic       lv2, lr2, so2, sv2, wd2, bz2;
   logic [7:0] ld2;

   int n_checks;
   int n_fail;

   serial_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_msb (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (lv1),
      .load_ready (lr1),
      .load_data  (ld1),
      .sout       (so1),
      .sout_valid (sv1),
      .word_done  (wd1),
      .busy       (bz1)
   );

   serial_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_lsb (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (lv2),
      .load_ready (lr2),
      .load_data  (ld2),
      .sout       (so2),
      .sout_valid (sv2),
      .word_done  (wd2),
      .busy       (bz2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference Moore detector for 1011 (overlapping), fed by the MSB-first DUT.
   logic [2:0] det_q;
   logic       det_out;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         det_q <= 3'd0;
      end else begin
         case (det_q)
            3'd0:    det_q <= so1 ? 3'd1 : 3'd0;
            3'd1:    det_q <= so1 ? 3'd1 : 3'd2;
            3'd2:    det_q <= so1 ? 3'd3 : 3'd0;
            3'd3:    det_q <= so1 ? 3'd4 : 3'd2;
            default: det_q <= so1 ? 3'd1 : 3'd2;
         endcase
      end
   end
   assign det_out = (det_q == 3'd4);

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0]  w8;
   logic [15:0] w16;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      lv1 = 1'b0; ld1 = 8'h00;
      lv2 = 1'b0; ld2 = 8'h00;

      // Reset state
      #12;
      check_val("rst_sout",       {31'd0, so1}, 32'd0);
      check_val("rst_sout_valid", {31'd0, sv1}, 32'd0);
      check_val("rst_word_done",  {31'd0, wd1}, 32'd0);
      check_val("rst_busy",       {31'd0, bz1}, 32'd0);
      check_val("rst_load_ready", {31'd0, lr1}, 32'd1);
      tick();
      rst_n = 1'b1;
      tick();

      // 1. Single word B0 (MSB first)
      w8  = 8'hB0;
      lv1 = 1'b1; ld1 = w8;
      check_val("t1_ready_c0", {31'd0, lr1}, 32'd1);
      tick();
      lv1 = 1'b0; ld1 = 8'h00;
      for (int c = 1; c <= 8; c++) begin
         check_val($sformatf("t1_sout_c%0d", c), {31'd0, so1}, {31'd0, w8[8-c]});
         check_val($sformatf("t1_valid_c%0d", c), {31'd0, sv1}, 32'd1);
         check_val($sformatf("t1_done_c%0d", c), {31'd0, wd1}, (c == 8) ? 32'd1 : 32'd0);
         check_val($sformatf("t1_det_c%0d", c), {31'd0, det_out}, (c == 5) ? 32'd1 : 32'd0);
         tick();
      end
      check_val("t1_valid_c9", {31'd0, sv1}, 32'd0);
      check_val("t1_sout_c9",  {31'd0, so1}, 32'd0);
      check_val("t1_busy_c9",  {31'd0, bz1}, 32'd0);
      check_val("t1_done_c9",  {31'd0, wd1}, 32'd0);
      tick(); tick();

      // 2. Back-to-back A5 then 3C with valid held high
      w16 = 16'hA53C;
      lv1 = 1'b1; ld1 = 8'hA5;
      tick();
      for (int c = 1; c <= 16; c++) begin
         check_val($sformatf("t2_sout_c%0d", c), {31'd0, so1}, {31'd0, w16[16-c]});
         check_val($sformatf("t2_valid_c%0d", c), {31'd0, sv1}, 32'd1);
         if (c <= 9)
            check_val($sformatf("t2_ready_c%0d", c), {31'd0, lr1},
                      (c >= 2 && c <= 8) ? 32'd0 : 32'd1);
         if (c == 1) ld1 = 8'h3C;
         else        lv1 = 1'b0;
         tick();
      end
      check_val("t2_valid_c17", {31'd0, sv1}, 32'd0);
      tick(); tick();

      // 3. Bypass: next word presented only in the word_done cycle
      w16 = 16'h81FF;
      lv1 = 1'b1; ld1 = 8'h81;
      tick();
      lv1 = 1'b0; ld1 = 8'h00;
      for (int c = 1; c <= 16; c++) begin
         check_val($sformatf("t3_sout_c%0d", c), {31'd0, so1}, {31'd0, w16[16-c]});
         check_val($sformatf("t3_valid_c%0d", c), {31'd0, sv1}, 32'd1);
         check_val($sformatf("t3_ready_c%0d", c), {31'd0, lr1}, 32'd1);
         check_val($sformatf("t3_done_c%0d", c), {31'd0, wd1},
                   (c == 8 || c == 16) ? 32'd1 : 32'd0);
         if (c == 8) begin lv1 = 1'b1; ld1 = 8'hFF; end
         else        begin lv1 = 1'b0; ld1 = 8'h00; end
         tick();
      end
      check_val("t3_valid_c17", {31'd0, sv1}, 32'd0);
      tick(); tick();

      // 4. LSB first, 0D -> 1,0,1,1,0,0,0,0
      w8  = 8'b1011_0000;
      lv2 = 1'b1; ld2 = 8'h0D;
      tick();
      lv2 = 1'b0; ld2 = 8'h00;
      for (int c = 1; c <= 8; c++) begin
         check_val($sformatf("t4_sout_c%0d", c), {31'd0, so2}, {31'd0, w8[8-c]});
         check_val($sformatf("t4_done_c%0d", c), {31'd0, wd2}, (c == 8) ? 32'd1 : 32'd0);
         tick();
      end
      check_val("t4_valid_c9", {31'd0, sv2}, 32'd0);
      tick(); tick();

      // 5. Reset mid-word with a second word held
      lv1 = 1'b1; ld1 = 8'hFF;
      tick();
      ld1 = 8'hAA;
      tick();
      lv1 = 1'b0; ld1 = 8'h00;
      tick();
      check_val("t5_busy_c3",  {31'd0, bz1}, 32'd1);
      check_val("t5_ready_c3", {31'd0, lr1}, 32'd0);
      check_val("t5_sout_c3",  {31'd0, so1}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t5_rst_sout",  {31'd0, so1}, 32'd0);
      check_val("t5_rst_valid", {31'd0, sv1}, 32'd0);
      check_val("t5_rst_busy",  {31'd0, bz1}, 32'd0);
      check_val("t5_rst_ready", {31'd0, lr1}, 32'd1);
      check_val("t5_rst_done",  {31'd0, wd1}, 32'd0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         check_val($sformatf("t5_post_valid_%0d", c), {31'd0, sv1}, 32'd0);
         check_val($sformatf("t5_post_sout_%0d", c), {31'd0, so1}, 32'd0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

endmodule : tb_serial_feeder
`default_nettype wire
